// File: rtl/neuron_decay_sequencer.sv
// Sweeps the membrane-potential RAM through the decay unit once per start pulse.
// Optional build macro DECAY_SEQ_SKIP_ZERO_EN: zero potentials bypass the decay unit.
//
// state | meaning
// IDLE  | waiting for start, mode latched on accept
// READ  | rd_en high for current index
// LATCH | rd_data captured into decay_new_potential
// LOAD  | one-cycle decay_load strobe, wait counter armed
// WAIT  | settle countdown
// STEP  | one-cycle decay_time_step strobe
// WRITE | decayed potential written back to the same index
// DONE  | one-cycle done pulse, busy still high
module neuron_decay_sequencer #(
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_W      = 4,
    parameter int DECAY_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode_in,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              decay_load,
    output logic              decay_time_step,
    output logic [2:0]        decay_mode,
    output logic [31:0]       decay_new_potential,
    input  logic [31:0]       decay_output_potential
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_LOAD, S_WAIT, S_STEP, S_WRITE, S_DONE
    } state_t;

    localparam int                CNT_W     = (DECAY_WAIT > 1) ? $clog2(DECAY_WAIT) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(DECAY_WAIT - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic              last;
    logic              skip_zero;

    assign last = (idx == LAST_IDX);

`ifdef DECAY_SEQ_SKIP_ZERO_EN
    assign skip_zero = (rd_data == 32'd0);
`else
    assign skip_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  state_nxt = S_LATCH;
            S_LATCH: begin
                if (skip_zero) state_nxt = last ? S_DONE : S_READ;
                else           state_nxt = S_LOAD;
            end
            S_LOAD:  state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == '0) state_nxt = S_STEP;
            S_STEP:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = last ? S_DONE : S_READ;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx                 <= '0;
            wait_cnt            <= '0;
            decay_mode          <= '0;
            decay_new_potential <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        decay_mode <= mode_in;
                        idx        <= '0;
                    end
                end
                S_LATCH: begin
                    decay_new_potential <= rd_data;
                    if (skip_zero && !last) idx <= idx + ADDR_W'(1);
                end
                S_LOAD:  wait_cnt <= WAIT_INIT;
                S_WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
                S_WRITE: if (!last) idx <= idx + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    // Strobes are registered decodes of the state being entered, so each is
    // glitch-free and lines up exactly with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            rd_en           <= 1'b0;
            wr_en           <= 1'b0;
            decay_load      <= 1'b0;
            decay_time_step <= 1'b0;
        end else begin
            busy            <= (state_nxt != S_IDLE);
            done            <= (state_nxt == S_DONE);
            rd_en           <= (state_nxt == S_READ);
            wr_en           <= (state_nxt == S_WRITE);
            decay_load      <= (state_nxt == S_LOAD);
            decay_time_step <= (state_nxt == S_STEP);
        end
    end

    // The decay unit updates its output on the STEP->WRITE edge, so write data
    // must pass straight through rather than be captured a cycle early.
    assign rd_addr = rd_en ? idx : '0;
    assign wr_addr = wr_en ? idx : '0;
    assign wr_data = wr_en ? decay_output_potential : '0;

endmodule
